renode_bus_bridge: RTL and testbench

RENODE_BUS_BRIDGE -- requirements
Module: renode_bus_bridge

---
 rtl/renode_bus_bridge_if.sv | 45 ++++
 rtl/renode_bus_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_renode_bus_bridge.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/renode_bus_bridge_if.sv
// Request, response and bus-controller signals of the Renode bus bridge.
// The slave modport is the bridge's view; master is the surrounding system's view.
interface renode_bus_bridge_if #(
   parameter int AddressWidth = 32,
   parameter int DataWidth    = 32
);
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_write;
   logic [AddressWidth-1:0]   req_address;
   logic [DataWidth-1:0]      req_data;
   logic [1:0]                req_size;

   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [DataWidth-1:0]      rsp_data;
   logic [1:0]                rsp_status;

   logic                      bus_valid;
   logic                      bus_write;
   logic [AddressWidth-1:0]   bus_address;
   logic [DataWidth-1:0]      bus_wdata;
   logic [DataWidth/8-1:0]    bus_strobe;
   logic                      bus_ready;
   logic [DataWidth-1:0]      bus_rdata;
   logic                      bus_error;

   modport slave (
      input  req_valid, req_write, req_address, req_data, req_size,
      output req_ready,
      output rsp_valid, rsp_data, rsp_status,
      input  rsp_ready,
      output bus_valid, bus_write, bus_address, bus_wdata, bus_strobe,
      input  bus_ready, bus_rdata, bus_error
   );

   modport master (
      output req_valid, req_write, req_address, req_data, req_size,
      input  req_ready,
      input  rsp_valid, rsp_data, rsp_status,
      output rsp_ready,
      input  bus_valid, bus_write, bus_address, bus_wdata, bus_strobe,
      output bus_ready, bus_rdata, bus_error
   );
endinterface

// File: rtl/renode_bus_bridge.sv
// Queues sized read/write requests and issues them one at a time to a word-wide bus,
// handling byte-lane placement, misalignment, bus errors and a bus-wait timeout.
module renode_bus_bridge #(
   parameter int AddressWidth  = 32,
   parameter int DataWidth     = 32,
   parameter int QueueDepth    = 4,
   parameter int TimeoutCycles = 100
) (
   input  logic                          clk,
   input  logic                          rst_n,
   renode_bus_bridge_if.slave            io,
   output logic                          busy,
   output logic [$clog2(QueueDepth):0]   queue_level
);
   localparam int ByteLanes   = DataWidth / 8;
   localparam int OffsetWidth = $clog2(ByteLanes);
   localparam int PtrWidth    = $clog2(QueueDepth);
   localparam int LevelWidth  = PtrWidth + 1;
   localparam int CountWidth  = $clog2(TimeoutCycles + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] RESPOND = 2'd2;

   localparam logic [1:0] STATUS_OK         = 2'd0;
   localparam logic [1:0] STATUS_BUS_ERROR  = 2'd1;
   localparam logic [1:0] STATUS_TIMEOUT    = 2'd2;
   localparam logic [1:0] STATUS_MISALIGNED = 2'd3;

   generate
      if (DataWidth != 32 && DataWidth != 64) begin : g_bad_data_width
         $error("renode_bus_bridge: DataWidth must be 32 or 64");
      end
      if (QueueDepth < 2 || (QueueDepth & (QueueDepth - 1)) != 0) begin : g_bad_queue_depth
         $error("renode_bus_bridge: QueueDepth must be a power of two >= 2");
      end
      if (TimeoutCycles < 1) begin : g_bad_timeout
         $error("renode_bus_bridge: TimeoutCycles must be >= 1");
      end
   endgenerate

   logic                      q_write   [QueueDepth];
   logic [AddressWidth-1:0]   q_address [QueueDepth];
   logic [DataWidth-1:0]      q_data    [QueueDepth];
   logic [1:0]                q_size    [QueueDepth];
   logic [PtrWidth-1:0]       wr_ptr;
   logic [PtrWidth-1:0]       rd_ptr;
   logic [LevelWidth-1:0]     level;

   logic [1:0]                state;
   logic [CountWidth-1:0]     timer;
   logic [OffsetWidth-1:0]    cur_offset;
   logic [1:0]                cur_size;
   logic                      bus_write_q;
   logic [AddressWidth-1:0]   bus_address_q;
   logic [DataWidth-1:0]      bus_wdata_q;
   logic [ByteLanes-1:0]      bus_strobe_q;
   logic [DataWidth-1:0]      rsp_data_q;
   logic [1:0]                rsp_status_q;

   logic                      push;
   logic                      pop;

   assign io.req_ready = (level != LevelWidth'(QueueDepth));
   assign push         = io.req_valid && io.req_ready;
   assign pop          = (state == IDLE) && (level != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         q_write[wr_ptr]   <= io.req_write;
         q_address[wr_ptr] <= io.req_address;
         q_data[wr_ptr]    <= io.req_data;
         q_size[wr_ptr]    <= io.req_size;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   logic                      head_write;
   logic [AddressWidth-1:0]   head_address;
   logic [DataWidth-1:0]      head_data;
   logic [1:0]                head_size;
   logic [OffsetWidth-1:0]    head_offset;
   logic [2:0]                size_mask;
   logic [7:0]                lane_ones;
   logic                      head_misaligned;
   logic [ByteLanes-1:0]      head_strobe;
   logic [DataWidth-1:0]      head_wdata;

   assign head_write   = q_write[rd_ptr];
   assign head_address = q_address[rd_ptr];
   assign head_data    = q_data[rd_ptr];
   assign head_size    = q_size[rd_ptr];
   assign head_offset  = head_address[OffsetWidth-1:0];

   always_comb begin
      size_mask = 3'b000;
      lane_ones = 8'h01;
      case (head_size)
         2'd0:    begin size_mask = 3'b000; lane_ones = 8'h01; end
         2'd1:    begin size_mask = 3'b001; lane_ones = 8'h03; end
         2'd2:    begin size_mask = 3'b011; lane_ones = 8'h0F; end
         default: begin size_mask = 3'b111; lane_ones = 8'hFF; end
      endcase
   end

   // A qword cannot fit a 32-bit bus at all, so it is treated as misaligned.
   assign head_misaligned = ((head_address[2:0] & size_mask) != 3'b000) ||
                            ((head_size == 2'd3) && (DataWidth == 32));
   assign head_strobe     = ByteLanes'(lane_ones) << head_offset;
   assign head_wdata      = head_data << {head_offset, 3'b000};

   logic [DataWidth-1:0]      read_shifted;
   logic [DataWidth-1:0]      read_mask;

   assign read_shifted = io.bus_rdata >> {cur_offset, 3'b000};

   always_comb begin
      read_mask = '1;
      case (cur_size)
         2'd0:    read_mask = DataWidth'(8'hFF);
         2'd1:    read_mask = DataWidth'(16'hFFFF);
         2'd2:    read_mask = DataWidth'(32'hFFFF_FFFF);
         default: read_mask = '1;
      endcase
   end

   // Bus request fields are captured at pop so they stay stable for the whole ISSUE state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         timer         <= '0;
         cur_offset    <= '0;
         cur_size      <= '0;
         bus_write_q   <= 1'b0;
         bus_address_q <= '0;
         bus_wdata_q   <= '0;
         bus_strobe_q  <= '0;
         rsp_data_q    <= '0;
         rsp_status_q  <= STATUS_OK;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  cur_offset <= head_offset;
                  cur_size   <= head_size;
                  if (head_misaligned) begin
                     state        <= RESPOND;
                     rsp_status_q <= STATUS_MISALIGNED;
                     rsp_data_q   <= '0;
                  end else begin
                     state         <= ISSUE;
                     timer         <= '0;
                     bus_write_q   <= head_write;
                     bus_address_q <= {head_address[AddressWidth-1:OffsetWidth], {OffsetWidth{1'b0}}};
                     bus_strobe_q  <= head_strobe;
                     bus_wdata_q   <= head_wdata;
                  end
               end
            end
            ISSUE: begin
               // Completion is tested first so it wins on the edge the timeout would expire.
               if (io.bus_ready) begin
                  state        <= RESPOND;
                  rsp_status_q <= io.bus_error ? STATUS_BUS_ERROR : STATUS_OK;
                  rsp_data_q   <= bus_write_q ? '0 : (read_shifted & read_mask);
               end else if (timer == CountWidth'(TimeoutCycles - 1)) begin
                  state        <= RESPOND;
                  rsp_status_q <= STATUS_TIMEOUT;
                  rsp_data_q   <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RESPOND: begin
               if (io.rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign io.bus_valid   = (state == ISSUE);
   assign io.bus_write   = bus_write_q;
   assign io.bus_address = bus_address_q;
   assign io.bus_wdata   = bus_wdata_q;
   assign io.bus_strobe  = bus_strobe_q;
   assign io.rsp_valid   = (state == RESPOND);
   assign io.rsp_data    = rsp_data_q;
   assign io.rsp_status  = rsp_status_q;
   assign busy           = (state != IDLE) || (level != '0);
   assign queue_level    = level;
endmodule

// File: tb/tb_renode_bus_bridge.sv
// Directed and randomized checks of renode_bus_bridge against a transaction-level
// reference model of request placement, response data and status.
module tb_renode_bus_bridge;
   localparam int TimeoutCycles = 4;

   typedef struct {
      logic        write;
      logic [31:0] address;
      logic [31:0] data;
      logic [1:0]  size;
      logic [31:0] rdata;
      logic        error;
      int          delay;
   } txn_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       busy;
   logic [2:0] queue_level;
   txn_t       expected_q[$];
   int         assert_count = 0;
   int         fail_count = 0;

   renode_bus_bridge_if #(.AddressWidth(32), .DataWidth(32)) bus_if ();

   renode_bus_bridge #(
      .AddressWidth(32), .DataWidth(32), .QueueDepth(4), .TimeoutCycles(TimeoutCycles)
   ) dut (
      .clk(clk), .rst_n(rst_n), .io(bus_if), .busy(busy), .queue_level(queue_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assert_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Expected bus request and response, derived from byte offsets and sizes.
   function automatic void model(input txn_t t, output logic mis, output logic [31:0] baddr,
                                 output logic [3:0] strobe, output logic [31:0] wdata,
                                 output logic [1:0] status, output logic [31:0] rdata);
      logic [63:0] off, nbytes, wide;
      off    = {32'd0, t.address} % 64'd4;
      nbytes = 64'd1 << t.size;
      mis    = (t.size == 2'd3) || (({32'd0, t.address} % nbytes) != 64'd0);
      baddr  = t.address - off[31:0];
      wide   = ((64'd1 << nbytes) - 64'd1) << off;
      strobe = wide[3:0];
      wide   = {32'd0, t.data} << (64'd8 * off);
      wdata  = wide[31:0];
      if (mis) status = 2'd3;
      else if (t.delay >= TimeoutCycles) status = 2'd2;
      else status = {1'b0, t.error};
      if (status >= 2'd2 || t.write) begin
         rdata = 32'd0;
      end else begin
         wide  = ({32'd0, t.rdata} >> (64'd8 * off)) & ((64'd1 << (64'd8 * nbytes)) - 64'd1);
         rdata = wide[31:0];
      end
   endfunction

   function automatic txn_t make_txn(input logic write, input logic [31:0] address, input logic [31:0] data,
                                     input logic [1:0] size, input logic [31:0] rdata, input logic error,
                                     input int delay);
      txn_t t;
      t.write = write; t.address = address; t.data = data; t.size = size;
      t.rdata = rdata; t.error = error; t.delay = delay;
      return t;
   endfunction

   function automatic txn_t random_txn();
      return make_txn(1'($urandom_range(0, 1)), 32'h4000 + 32'($urandom_range(0, 15)), $urandom,
                      2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0),
                      int'($urandom_range(0, 5)));
   endfunction

   // Presents one request from a negedge and returns on the negedge after it is accepted.
   task automatic apply_stimulus(input txn_t t);
      bit done = 1'b0;
      bus_if.req_valid   = 1'b1;
      bus_if.req_write   = t.write;
      bus_if.req_address = t.address;
      bus_if.req_data    = t.data;
      bus_if.req_size    = t.size;
      for (int i = 0; i < 50 && !done; i++) begin
         if (bus_if.req_ready) done = 1'b1;
         @(negedge clk);
      end
      bus_if.req_valid = 1'b0;
      check("push_accepted", 64'(done), 64'd1);
      if (done) expected_q.push_back(t);
   endtask

   task automatic finish_rsp(input logic [1:0] status, input logic [31:0] rdata);
      int hold = int'($urandom_range(0, 2));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("rsp_hold_valid", 64'(bus_if.rsp_valid), 64'd1);
         check("rsp_hold_status", 64'(bus_if.rsp_status), 64'(status));
         check("rsp_hold_data", 64'(bus_if.rsp_data), 64'(rdata));
      end
      bus_if.rsp_ready = 1'b1;
      @(negedge clk);
      bus_if.rsp_ready = 1'b0;
      check("rsp_released", 64'(bus_if.rsp_valid), 64'd0);
   endtask

   // Services the oldest expected transaction: bus side, then response side.
   task automatic check_output(input bit hold_rsp, output int waited,
                               output logic [1:0] status, output logic [31:0] rdata);
      txn_t t;
      logic mis;
      logic [31:0] baddr, wdata;
      logic [3:0] strobe;
      int low_edges;
      waited = -1; status = 2'd0; rdata = 32'd0;
      if (expected_q.size() == 0) begin
         check("scoreboard_nonempty", 64'd0, 64'd1);
         return;
      end
      t = expected_q.pop_front();
      model(t, mis, baddr, strobe, wdata, status, rdata);
      waited = 0;
      while (!bus_if.bus_valid && !bus_if.rsp_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!mis) begin
         check("bus_valid", 64'(bus_if.bus_valid), 64'd1);
         check("bus_write", 64'(bus_if.bus_write), 64'(t.write));
         check("bus_address", 64'(bus_if.bus_address), 64'(baddr));
         check("bus_strobe", 64'(bus_if.bus_strobe), 64'(strobe));
         check("bus_wdata", 64'(bus_if.bus_wdata), 64'(wdata));
         low_edges = (t.delay < TimeoutCycles) ? t.delay : TimeoutCycles;
         for (int k = 0; k < low_edges; k++) begin
            bus_if.bus_ready = 1'b0;
            @(negedge clk);
            if (t.delay < TimeoutCycles || k < low_edges - 1) begin
               check("bus_wait_valid", 64'(bus_if.bus_valid), 64'd1);
               check("bus_wait_address", 64'(bus_if.bus_address), 64'(baddr));
            end
         end
         if (t.delay < TimeoutCycles) begin
            bus_if.bus_ready = 1'b1;
            bus_if.bus_rdata = t.rdata;
            bus_if.bus_error = t.error;
            @(negedge clk);
            bus_if.bus_ready = 1'b0;
            bus_if.bus_error = 1'b0;
            bus_if.bus_rdata = $urandom;
         end
      end
      check("bus_valid_done", 64'(bus_if.bus_valid), 64'd0);
      check("rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
      check("rsp_status", 64'(bus_if.rsp_status), 64'(status));
      check("rsp_data", 64'(bus_if.rsp_data), 64'(rdata));
      if (!hold_rsp) finish_rsp(status, rdata);
   endtask

   initial begin
      int waited, batch;
      logic [1:0] st;
      logic [31:0] rd;
      txn_t t;

      bus_if.req_valid = 1'b0; bus_if.req_write = 1'b0; bus_if.req_address = '0;
      bus_if.req_data = '0; bus_if.req_size = '0; bus_if.rsp_ready = 1'b0;
      bus_if.bus_ready = 1'b0; bus_if.bus_rdata = 32'h1234_5678; bus_if.bus_error = 1'b0;

      repeat (2) @(negedge clk);
      check("reset_req_ready", 64'(bus_if.req_ready), 64'd1);
      check("reset_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
      check("reset_rsp_data", 64'(bus_if.rsp_data), 64'd0);
      check("reset_rsp_status", 64'(bus_if.rsp_status), 64'd0);
      check("reset_bus_valid", 64'(bus_if.bus_valid), 64'd0);
      check("reset_bus_write", 64'(bus_if.bus_write), 64'd0);
      check("reset_bus_address", 64'(bus_if.bus_address), 64'd0);
      check("reset_bus_wdata", 64'(bus_if.bus_wdata), 64'd0);
      check("reset_bus_strobe", 64'(bus_if.bus_strobe), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_queue_level", 64'(queue_level), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] dword read, byte write, misaligned, qword, bus error");
      apply_stimulus(make_txn(1'b0, 32'h1004, 32'h0, 2'd2, 32'hDEAD_BEEF, 1'b0, 3));
      check_output(1'b0, waited, st, rd);
      check("latency_dword_read", 64'(waited), 64'd1);
      check("dword_read_data", 64'(rd), 64'hDEAD_BEEF);
      apply_stimulus(make_txn(1'b1, 32'h1003, 32'hA5, 2'd0, 32'h0, 1'b0, 1));
      check_output(1'b0, waited, st, rd);
      apply_stimulus(make_txn(1'b0, 32'h1001, 32'h0, 2'd1, 32'hFFFF_FFFF, 1'b0, 0));
      check_output(1'b0, waited, st, rd);
      check("latency_misaligned", 64'(waited), 64'd1);
      apply_stimulus(make_txn(1'b0, 32'h1000, 32'h0, 2'd3, 32'hFFFF_FFFF, 1'b0, 0));
      check_output(1'b0, waited, st, rd);
      apply_stimulus(make_txn(1'b0, 32'h1002, 32'h0, 2'd1, 32'hCAFE_F00D, 1'b1, 0));
      check_output(1'b0, waited, st, rd);
      check("idle_busy", 64'(busy), 64'd0);

      $display("[TB] timeout and stray bus_ready");
      apply_stimulus(make_txn(1'b0, 32'h1008, 32'h0, 2'd2, 32'h5555_AAAA, 1'b0, 9));
      check_output(1'b1, waited, st, rd);
      bus_if.bus_ready = 1'b1; bus_if.bus_error = 1'b1;
      @(negedge clk);
      check("stray_rsp_status", 64'(bus_if.rsp_status), 64'd2);
      check("stray_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
      bus_if.bus_ready = 1'b0; bus_if.bus_error = 1'b0;
      finish_rsp(st, rd);
      bus_if.bus_ready = 1'b1;
      @(negedge clk);
      bus_if.bus_ready = 1'b0;
      check("stray_idle_bus_valid", 64'(bus_if.bus_valid), 64'd0);
      check("stray_idle_busy", 64'(busy), 64'd0);

      $display("[TB] queue fill with response back-pressure");
      apply_stimulus(make_txn(1'b0, 32'h1001, 32'h0, 2'd1, 32'h0, 1'b0, 0));
      apply_stimulus(make_txn(1'b0, 32'h1003, 32'h0, 2'd2, 32'h0, 1'b0, 0));
      for (int i = 0; i < 3; i++) apply_stimulus(random_txn());
      check("full_level", 64'(queue_level), 64'd4);
      check("full_req_ready", 64'(bus_if.req_ready), 64'd0);
      check("full_busy", 64'(busy), 64'd1);
      t = expected_q.pop_front();
      check("blocker_status", 64'(bus_if.rsp_status), 64'd3);
      t = random_txn();
      bus_if.req_valid = 1'b1; bus_if.req_write = t.write; bus_if.req_address = t.address;
      bus_if.req_data = t.data; bus_if.req_size = t.size;
      @(negedge clk);
      check("full_hold_level", 64'(queue_level), 64'd4);
      bus_if.rsp_ready = 1'b1;
      @(negedge clk);
      bus_if.rsp_ready = 1'b0;
      check("handshake_level", 64'(queue_level), 64'd4);
      check("handshake_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
      @(negedge clk);
      check("pop_level", 64'(queue_level), 64'd3);
      check("pop_req_ready", 64'(bus_if.req_ready), 64'd1);
      @(negedge clk);
      bus_if.req_valid = 1'b0;
      expected_q.push_back(t);
      check("refill_level", 64'(queue_level), 64'd4);
      for (int i = 0; i < 5; i++) check_output(1'b0, waited, st, rd);
      check("drain_busy", 64'(busy), 64'd0);

      $display("[TB] reset during ISSUE with two queued");
      apply_stimulus(make_txn(1'b0, 32'h2000, 32'h0, 2'd2, 32'h0, 1'b0, 0));
      apply_stimulus(random_txn());
      apply_stimulus(random_txn());
      check("pre_reset_bus_valid", 64'(bus_if.bus_valid), 64'd1);
      check("pre_reset_level", 64'(queue_level), 64'd2);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_bus_valid", 64'(bus_if.bus_valid), 64'd0);
      check("async_reset_level", 64'(queue_level), 64'd0);
      check("async_reset_busy", 64'(busy), 64'd0);
      expected_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus_if.bus_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("post_reset_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
         check("post_reset_bus_valid", 64'(bus_if.bus_valid), 64'd0);
      end
      bus_if.bus_ready = 1'b0;

      $display("[TB] randomized batches");
      for (int b = 0; b < 12; b++) begin
         batch = int'($urandom_range(1, 3));
         apply_stimulus(random_txn());
         check_output(1'b1, waited, st, rd);
         for (int i = 1; i < batch; i++) apply_stimulus(random_txn());
         check("batch_level", 64'(queue_level), 64'(batch - 1));
         finish_rsp(st, rd);
         for (int i = 1; i < batch; i++) begin
            check_output(1'b0, waited, st, rd);
            check("next_pop_after_handshake", 64'(waited), 64'd1);
         end
         check("batch_idle", 64'(busy), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end
endmodule
